mux_rr_arbiter: RTL and testbench

Round-robin arbiter that shares one output channel between `N_REQ` requesters. It selects the data path through an N-way mux and registers the winner's beat into a single-entry output buffer. Multi-beat packets are supported: once a requester is granted, it keeps the grant until its `last` beat is transferred. It sits between several producer blocks and one shared consumer, and sequences access to the shared mux.

---
 rtl/mux_arb_pkg.sv | 12 +
 rtl/rr_pick.sv | 27 ++
 rtl/mux_rr_arbiter.sv | 117 +++++++++++
 tb/tb_mux_rr_arbiter.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/mux_arb_pkg.sv
// Shared types and default sizing for the round-robin mux arbiter.
package mux_arb_pkg;

  typedef enum logic {
    ARB,
    LOCK
  } arb_state_t;

  localparam int unsigned N_REQ_DEF = 4;
  localparam int unsigned W_DEF     = 8;

endpackage

// File: rtl/rr_pick.sv
// Combinational cyclic priority picker: first set bit of req scanning upward from ptr.
module rr_pick #(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          any,
  output logic [IW-1:0] idx
);

  int unsigned p;
  int unsigned j;

  always_comb begin
    any = |req;
    idx = '0;
    p   = 32'(ptr);
    j   = 0;
    // Scan from the farthest offset down so the nearest requester to ptr wins.
    for (int unsigned off = N; off > 0; off--) begin
      j = (p + off - 1) % N;
      if (req[j]) idx = IW'(j);
    end
  end

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin N-way mux arbiter with packet locking and a single-entry output buffer.
module mux_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int unsigned N_REQ = N_REQ_DEF,
  parameter int unsigned W     = W_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req_vld,
  input  logic [N_REQ-1:0]         req_last,
  input  logic [N_REQ*W-1:0]       req_data,
  output logic [N_REQ-1:0]         req_rdy,
  output logic                     out_vld,
  output logic [W-1:0]             out_data,
  output logic [$clog2(N_REQ)-1:0] out_src,
  output logic                     out_last,
  input  logic                     out_rdy
);

  localparam int unsigned IW = $clog2(N_REQ);

  arb_state_t    state, state_n;
  logic [IW-1:0] ptr, ptr_n;
  logic [IW-1:0] owner, owner_n;
  logic [IW-1:0] sel, sel_inc;
  logic [IW-1:0] pick_idx;
  logic          pick_any;
  logic          load_ok;
  logic          load;
  logic [W-1:0]  sel_data;
  logic          sel_last;

  rr_pick #(
    .N  (N_REQ),
    .IW (IW)
  ) u_pick (
    .req (req_vld),
    .ptr (ptr),
    .any (pick_any),
    .idx (pick_idx)
  );

  assign load_ok = !out_vld || out_rdy;
  assign sel     = (state == LOCK) ? owner : pick_idx;
  assign sel_inc = (sel == IW'(N_REQ - 1)) ? '0 : sel + IW'(1);

  always_comb begin
    sel_data = '0;
    sel_last = 1'b0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (sel == IW'(i)) begin
        sel_data = req_data[i*W +: W];
        sel_last = req_last[i];
      end
    end
  end

  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    owner_n = owner;
    req_rdy = '0;
    load    = 1'b0;
    if (!rst) begin
      unique case (state)
        ARB: begin
          if (load_ok && pick_any) begin
            req_rdy[pick_idx] = 1'b1;
            load              = 1'b1;
            if (sel_last) begin
              ptr_n = sel_inc;
            end else begin
              owner_n = pick_idx;
              state_n = LOCK;
            end
          end
        end
        LOCK: begin
          // Owner sees ready even when idle so a gap never releases the lock.
          req_rdy[owner] = load_ok;
          load           = load_ok && req_vld[owner];
          if (load && sel_last) begin
            ptr_n   = sel_inc;
            state_n = ARB;
          end
        end
        default: state_n = ARB;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ARB;
      ptr      <= '0;
      owner    <= '0;
      out_vld  <= 1'b0;
      out_data <= '0;
      out_src  <= '0;
      out_last <= 1'b0;
    end else begin
      state <= state_n;
      ptr   <= ptr_n;
      owner <= owner_n;
      if (load) begin
        out_vld  <= 1'b1;
        out_data <= sel_data;
        out_src  <= sel;
        out_last <= sel_last;
      end else if (out_rdy) begin
        out_vld <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Directed table-driven bench for mux_rr_arbiter (N_REQ=4, W=8).
module tb_mux_rr_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_vld;
  logic [3:0]  req_last;
  logic [31:0] req_data;
  logic [3:0]  req_rdy;
  logic        out_vld;
  logic [7:0]  out_data;
  logic [1:0]  out_src;
  logic        out_last;
  logic        out_rdy;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mux_rr_arbiter #(
    .N_REQ (4),
    .W     (8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req_vld  (req_vld),
    .req_last (req_last),
    .req_data (req_data),
    .req_rdy  (req_rdy),
    .out_vld  (out_vld),
    .out_data (out_data),
    .out_src  (out_src),
    .out_last (out_last),
    .out_rdy  (out_rdy)
  );

  typedef struct {
    logic [3:0]  vld;
    logic [3:0]  last;
    logic [31:0] data;
    logic        ordy;
    logic [3:0]  erdy;
    logic        evld;
    logic [1:0]  esrc;
    logic [7:0]  edata;
    logic        elast;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic [3:0] vld, logic [3:0] last, logic [31:0] data,
                              logic ordy, logic [3:0] erdy, logic evld,
                              logic [1:0] esrc, logic [7:0] edata, logic elast);
    vec_t v;
    v.vld = vld; v.last = last; v.data = data; v.ordy = ordy;
    v.erdy = erdy; v.evld = evld; v.esrc = esrc; v.edata = edata; v.elast = elast;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic evld, input logic [1:0] esrc,
                         input logic [7:0] edata, input logic elast);
    chk({tag, ".out_vld"}, 32'(out_vld), 32'(evld));
    chk({tag, ".out_src"}, 32'(out_src), 32'(esrc));
    chk({tag, ".out_data"}, 32'(out_data), 32'(edata));
    chk({tag, ".out_last"}, 32'(out_last), 32'(elast));
  endtask

  // Inputs are applied 1 time unit after a rising edge; req_rdy is checked
  // before the next edge and the registered outputs 1 unit after it.
  task automatic apply(input vec_t v, input string tag);
    req_vld  = v.vld;
    req_last = v.last;
    req_data = v.data;
    out_rdy  = v.ordy;
    #1;
    chk({tag, ".req_rdy"}, 32'(req_rdy), 32'(v.erdy));
    @(posedge clk);
    #1;
    chk_out(tag, v.evld, v.esrc, v.edata, v.elast);
  endtask

  initial begin
    rst      = 1'b1;
    req_vld  = 4'b1111;
    req_last = 4'b1111;
    req_data = 32'hA3A2A1A0;
    out_rdy  = 1'b1;
    @(posedge clk);
    #1;
    chk("rst.req_rdy", 32'(req_rdy), 32'h0);
    @(posedge clk);
    #1;
    chk_out("rst", 1'b0, 2'd0, 8'h00, 1'b0);
    rst = 1'b0;

    // idle
    for (int i = 0; i < 5; i++)
      vecs.push_back(mk(4'b0000, 4'b0000, 32'h0, 1'b1, 4'b0000, 1'b0, 2'd0, 8'h00, 1'b0));
    // single-beat round robin
    vecs.push_back(mk(4'b1111, 4'b1111, 32'hA3A2A1A0, 1'b1, 4'b0001, 1'b1, 2'd0, 8'hA0, 1'b1));
    vecs.push_back(mk(4'b1111, 4'b1111, 32'hA3A2A1A0, 1'b1, 4'b0010, 1'b1, 2'd1, 8'hA1, 1'b1));
    vecs.push_back(mk(4'b1111, 4'b1111, 32'hA3A2A1A0, 1'b1, 4'b0100, 1'b1, 2'd2, 8'hA2, 1'b1));
    vecs.push_back(mk(4'b1111, 4'b1111, 32'hA3A2A1A0, 1'b1, 4'b1000, 1'b1, 2'd3, 8'hA3, 1'b1));
    vecs.push_back(mk(4'b1111, 4'b1111, 32'hA3A2A1A0, 1'b1, 4'b0001, 1'b1, 2'd0, 8'hA0, 1'b1));
    vecs.push_back(mk(4'b0010, 4'b0010, 32'hA3A2A1A0, 1'b1, 4'b0010, 1'b1, 2'd1, 8'hA1, 1'b1));
    // 3-beat lock on requester 2 with requester 1 waiting, including an idle gap
    vecs.push_back(mk(4'b0110, 4'b0000, 32'h0011B100, 1'b1, 4'b0100, 1'b1, 2'd2, 8'h11, 1'b0));
    vecs.push_back(mk(4'b0110, 4'b0000, 32'h0022B100, 1'b1, 4'b0100, 1'b1, 2'd2, 8'h22, 1'b0));
    vecs.push_back(mk(4'b0010, 4'b0000, 32'h0000B100, 1'b1, 4'b0100, 1'b0, 2'd2, 8'h22, 1'b0));
    vecs.push_back(mk(4'b0110, 4'b0100, 32'h0033B100, 1'b1, 4'b0100, 1'b1, 2'd2, 8'h33, 1'b1));
    vecs.push_back(mk(4'b0010, 4'b0010, 32'h0000B100, 1'b1, 4'b0010, 1'b1, 2'd1, 8'hB1, 1'b1));
    // back-pressure: hold for 4 cycles, then drain and load together
    for (int i = 0; i < 4; i++)
      vecs.push_back(mk(4'b0001, 4'b0001, 32'h000000C0, 1'b0, 4'b0000, 1'b1, 2'd1, 8'hB1, 1'b1));
    vecs.push_back(mk(4'b0001, 4'b0001, 32'h000000C0, 1'b1, 4'b0001, 1'b1, 2'd0, 8'hC0, 1'b1));
    // wrap-around from ptr=3
    vecs.push_back(mk(4'b0100, 4'b0100, 32'h00D20000, 1'b1, 4'b0100, 1'b1, 2'd2, 8'hD2, 1'b1));
    vecs.push_back(mk(4'b1001, 4'b1001, 32'hE30000E0, 1'b1, 4'b1000, 1'b1, 2'd3, 8'hE3, 1'b1));
    vecs.push_back(mk(4'b1001, 4'b1001, 32'hE30000E0, 1'b1, 4'b0001, 1'b1, 2'd0, 8'hE0, 1'b1));
    vecs.push_back(mk(4'b0000, 4'b0000, 32'h0, 1'b1, 4'b0000, 1'b0, 2'd0, 8'hE0, 1'b1));

    foreach (vecs[i]) apply(vecs[i], $sformatf("v%0d", i));

    // Reset during the second beat of a locked packet from requester 1 (ptr=1 here).
    apply(mk(4'b0010, 4'b0000, 32'h00005100, 1'b1, 4'b0010, 1'b1, 2'd1, 8'h51, 1'b0), "lock0");
    rst      = 1'b1;
    req_data = 32'h00005200;
    #1;
    chk("midrst.req_rdy", 32'(req_rdy), 32'h0);
    @(posedge clk);
    #1;
    chk_out("midrst", 1'b0, 2'd0, 8'h00, 1'b0);
    rst = 1'b0;
    // ptr back at 0 and state ARB: requester 0 beats requester 2.
    apply(mk(4'b0101, 4'b0101, 32'h00620060, 1'b1, 4'b0001, 1'b1, 2'd0, 8'h60, 1'b1), "post0");
    apply(mk(4'b0100, 4'b0100, 32'h00620000, 1'b1, 4'b0100, 1'b1, 2'd2, 8'h62, 1'b1), "post1");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
